fetch_ctrl: RTL

Instruction-fetch sequencer for the core's instruction memory. Memory is halfword-addressed, combinational-read, and returns {M[a+1], M[a]} for address a. fetch_ctrl owns the PC and the boot-vector load, splits 16-bit and 32-bit instructions, and drives a registered instruction slot to decode with valid/ready backpressure. It also handles branch redirect/flush, HLT, and out-of-range fetch faults.

---
 rtl/fetch_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer. Owns the halfword PC, loads the boot vector,
// splits 16/32-bit instructions and presents them to decode in a registered
// slot with valid/ready backpressure. Handles redirect/flush, HLT and
// out-of-range fetch faults.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   mem_addr        halfword address to instruction memory
//   mem_data        {M[a+1], M[a]} for mem_addr, same cycle
//   dec_ready       decode accepts the slot this cycle
//   instr           slot instruction (16-bit zero-extended, or {hw0, hw1})
//   instr_valid     slot holds an instruction
//   instr_len       0 = 16-bit, 1 = 32-bit
//   instr_pc        halfword address of the slot instruction
//   redirect_valid  branch/jump/flush request
//   redirect_pc     new PC for the redirect
//   halted          fetch stopped (HLT delivered or fault)
//   fetch_fault     sticky out-of-range fetch flag
// -----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter logic [31:0] RESET_VEC_ADDR = 32'd0,
   parameter int unsigned MEM_HW         = 1024,
   parameter int unsigned LONG_BIT       = 10,
   parameter logic [4:0]  HLT_OPC        = 5'b00001
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   input  logic        dec_ready,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        instr_len,
   output logic [31:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted,
   output logic        fetch_fault
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t      r_state, w_state_d;
   logic [31:0] r_pc, w_pc_d;
   logic [31:0] r_instr, w_instr_d;
   logic        r_valid, w_valid_d;
   logic        r_len, w_len_d;
   logic [31:0] r_ipc, w_ipc_d;
   logic        r_fault, w_fault_d;

   logic [15:0] w_hw0;
   logic [15:0] w_hw1;
   logic        w_long;
   logic [32:0] w_end;
   logic        w_oor;
   logic        w_load;

   // First-halfword decode and range check on the current fetch data.
   // The end address is computed in 33 bits so a PC near 2^32 cannot wrap
   // past the range check.
   always_comb begin
      w_hw0  = mem_data[15:0];
      w_hw1  = mem_data[31:16];
      w_long = w_hw0[LONG_BIT];
      w_end  = {1'b0, r_pc} + (w_long ? 33'd2 : 33'd1);
      w_oor  = w_end > 33'(MEM_HW);
      w_load = (r_state == S_RUN) && (!r_valid || dec_ready) && !redirect_valid;
   end

   always_comb begin
      w_state_d = r_state;
      w_pc_d    = r_pc;
      w_instr_d = r_instr;
      w_valid_d = r_valid;
      w_len_d   = r_len;
      w_ipc_d   = r_ipc;
      w_fault_d = r_fault;

      if (redirect_valid) begin
         // Flush wins over any handshake in the same cycle.
         w_pc_d    = redirect_pc;
         w_valid_d = 1'b0;
         w_state_d = S_RUN;
      end else begin
         case (r_state)
            S_BOOT: begin
               w_pc_d    = mem_data;
               w_state_d = S_RUN;
            end
            S_RUN: begin
               if (w_load) begin
                  if (w_oor) begin
                     w_valid_d = 1'b0;
                     w_fault_d = 1'b1;
                     w_state_d = S_HALT;
                  end else begin
                     w_instr_d = w_long ? {w_hw0, w_hw1} : {16'h0000, w_hw0};
                     w_len_d   = w_long;
                     w_ipc_d   = r_pc;
                     w_valid_d = 1'b1;
                     w_pc_d    = r_pc + (w_long ? 32'd2 : 32'd1);
                     // HLT is still delivered to decode before fetch stops.
                     if (w_hw0[15:11] == HLT_OPC) begin
                        w_state_d = S_HALT;
                     end
                  end
               end
            end
            S_HALT: begin
               if (r_valid && dec_ready) begin
                  w_valid_d = 1'b0;
               end
            end
            default: begin
               w_state_d = S_BOOT;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_BOOT;
         r_pc    <= 32'd0;
         r_instr <= 32'd0;
         r_valid <= 1'b0;
         r_len   <= 1'b0;
         r_ipc   <= 32'd0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_pc    <= w_pc_d;
         r_instr <= w_instr_d;
         r_valid <= w_valid_d;
         r_len   <= w_len_d;
         r_ipc   <= w_ipc_d;
         r_fault <= w_fault_d;
      end
   end

   assign mem_addr    = (r_state == S_BOOT) ? RESET_VEC_ADDR : r_pc;
   assign instr       = r_instr;
   assign instr_valid = r_valid;
   assign instr_len   = r_len;
   assign instr_pc    = r_ipc;
   assign halted      = (r_state == S_HALT);
   assign fetch_fault = r_fault;

endmodule
